// File: rtl/hazard_pkg.sv
// Shared constants for the RISC-V hazard scoreboard: width defaults, latency codes
// and a saturating counter helper.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int LAT_W_DEF      = 4;

  localparam logic [LAT_W_DEF-1:0] LAT_UNKNOWN = {LAT_W_DEF{1'b1}};
  localparam logic [LAT_W_DEF-1:0] LAT_LOAD    = 4'd1;
  localparam logic [LAT_W_DEF-1:0] LAT_MUL     = 4'd2;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
    if (en && (value != 32'hFFFF_FFFF)) begin
      return value + 32'd1;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: a fixed-latency countdown plus a wait-for-completion flag.
// The slot reports busy while either is pending.
module hazard_sb_entry #(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_count,
  input  logic             set_wait,
  input  logic             clear_wait,
  input  logic [LAT_W-1:0] lat,
  output logic             busy
);

  logic [LAT_W-1:0] count_r;
  logic             wait_r;

  // Countdown: an issue loads the latency, otherwise a pending count drains by one per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (set_count) begin
      count_r <= lat;
    end else if (count_r != '0) begin
      count_r <= count_r - LAT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Wait flag: set by a variable-latency issue, cleared by completion (set cannot collide with a real clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_r <= 1'b0;
    end else if (set_wait) begin
      wait_r <= 1'b1;
    end else if (clear_wait) begin
      wait_r <= 1'b0;
    end else begin
      wait_r <= wait_r;
    end
  end

  assign busy = (count_r != '0) | wait_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard beside ID: RAW/WAW detection and stall controls.
// Optional macro HAZARD_SB_PERF_EN adds saturating stall/RAW/WAW performance counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int NUM_REGS   = 32,
  parameter int LAT_W      = LAT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  id_flush,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_we,
  input  logic [LAT_W-1:0]      id_lat,
  input  logic                  wb_done,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic [NUM_REGS-1:0]   busy_vec
`ifdef HAZARD_SB_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_raw_events,
  output logic [31:0]           perf_waw_events
`endif
);

  localparam logic [LAT_W-1:0] LAT_VAR = {LAT_W{1'b1}};

  logic [NUM_REGS-1:0] busy_s;
  logic                raw_s;
  logic                waw_s;
  logic                stall_s;
  logic                issue_s;
  logic                rd_write_s;
  logic                lat_var_s;
  logic                lat_fixed_s;

  // Hazard detection reads registered busy state only, so the stall is zero-latency but loop-free.
  always_comb begin
    raw_s       = (id_rs1_used & busy_s[id_rs1]) | (id_rs2_used & busy_s[id_rs2]);
    waw_s       = id_rd_we & busy_s[id_rd];
    stall_s     = id_valid & ~id_flush & (raw_s | waw_s);
    issue_s     = id_valid & ~id_flush & ~stall_s;
    rd_write_s  = issue_s & id_rd_we & (id_rd != '0);
    lat_var_s   = (id_lat == LAT_VAR);
    lat_fixed_s = (id_lat != '0) & ~lat_var_s;
  end

  assign pc_write     = ~stall_s;
  assign if_id_write  = ~stall_s;
  assign id_ex_bubble = stall_s;
  assign busy_vec     = busy_s;

  // x0 is hard-wired zero and never pending.
  assign busy_s[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    hazard_sb_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_count  (rd_write_s & lat_fixed_s & (id_rd == REG_ADDR_W'(r))),
      .set_wait   (rd_write_s & lat_var_s & (id_rd == REG_ADDR_W'(r))),
      .clear_wait (wb_done & (wb_rd == REG_ADDR_W'(r))),
      .lat        (id_lat),
      .busy       (busy_s[r])
    );
  end

`ifdef HAZARD_SB_PERF_EN
  logic stall_prev_r;
  logic episode_s;

  assign episode_s = stall_s & ~stall_prev_r;

  // Episode events are classified on their first stalled cycle; RAW takes precedence over WAW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_prev_r      <= 1'b0;
      perf_stall_cycles <= 32'd0;
      perf_raw_events   <= 32'd0;
      perf_waw_events   <= 32'd0;
    end else begin
      stall_prev_r      <= stall_s;
      perf_stall_cycles <= sat_inc32(perf_stall_cycles, stall_s);
      perf_raw_events   <= sat_inc32(perf_raw_events, episode_s & raw_s);
      perf_waw_events   <= sat_inc32(perf_waw_events, episode_s & ~raw_s);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic
// against a per-register countdown/wait reference model.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid, id_flush, id_rs1_used, id_rs2_used, id_rd_we, wb_done;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic [3:0]  id_lat;
  logic        pc_write, if_id_write, id_ex_bubble;
  logic [31:0] busy_vec;
`ifdef HAZARD_SB_PERF_EN
  logic [31:0] perf_stall_cycles, perf_raw_events, perf_waw_events;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: remaining cycles per register and a waiting flag.
  int cnt_m[32];
  bit wt_m[32];

  hazard_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_flush     (id_flush),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_rd_we     (id_rd_we),
    .id_lat       (id_lat),
    .wb_done      (wb_done),
    .wb_rd        (wb_rd),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .id_ex_bubble (id_ex_bubble),
    .busy_vec     (busy_vec)
`ifdef HAZARD_SB_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_raw_events   (perf_raw_events),
    .perf_waw_events   (perf_waw_events)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit m_busy(input int r);
    return (r != 0) && ((cnt_m[r] > 0) || wt_m[r]);
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy(r);
    return v;
  endfunction

  function automatic bit m_stall();
    bit hz;
    hz = (id_rs1_used && m_busy(int'(id_rs1))) || (id_rs2_used && m_busy(int'(id_rs2))) ||
         (id_rd_we && m_busy(int'(id_rd)));
    return id_valid && !id_flush && hz;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 32; r++) begin
      cnt_m[r] = 0;
      wt_m[r]  = 1'b0;
    end
  endtask

  task automatic m_edge();
    bit iss;
    iss = id_valid && !id_flush && !m_stall();
    for (int r = 0; r < 32; r++) if (cnt_m[r] > 0) cnt_m[r]--;
    if (wb_done) wt_m[wb_rd] = 1'b0;
    if (iss && id_rd_we && id_rd != 5'd0) begin
      if (id_lat == 4'hF) wt_m[id_rd] = 1'b1;
      else if (id_lat != 4'd0) cnt_m[id_rd] = int'(id_lat);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic [3:0] lat, input logic wbd,
                       input logic [4:0] wbr);
    id_valid = v; id_flush = f; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2;
    id_rs2_used = u2; id_rd = rd; id_rd_we = we; id_lat = lat; wb_done = wbd; wb_rd = wbr;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 5'd0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    m_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #3;
    vec_cnt++;
    if (busy_vec !== 32'd0 || pc_write !== 1'b1 || if_id_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state: busy=%h pc=%b ifid=%b bub=%b, want 0/1/1/0",
               busy_vec, pc_write, if_id_write, id_ex_bubble);
    end
`ifdef HAZARD_SB_PERF_EN
    vec_cnt++;
    if (perf_stall_cycles !== 32'd0 || perf_raw_events !== 32'd0 || perf_waw_events !== 32'd0) begin
      err_cnt++;
      $display("FAIL reset_perf: %0d/%0d/%0d, want 0/0/0",
               perf_stall_cycles, perf_raw_events, perf_waw_events);
    end
`endif
    do_reset();
  endtask

  task automatic test_load_use();
    int n;
    do_reset();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, LAT_LOAD, 1'b0, 5'd0);
    vec_cnt++;
    if (pc_write !== 1'b1) begin
      err_cnt++;
      $display("FAIL load_issue: pc_write=%b want 1", pc_write);
    end
    tick();
    drive(1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 4'd0, 1'b0, 5'd0);
    vec_cnt++;
    if (id_ex_bubble !== 1'b1 || pc_write !== 1'b0 || if_id_write !== 1'b0 || busy_vec[5] !== 1'b1) begin
      err_cnt++;
      $display("FAIL load_use_stall: bub=%b pc=%b ifid=%b busy5=%b want 1/0/0/1",
               id_ex_bubble, pc_write, if_id_write, busy_vec[5]);
    end
    n = 0;
    while (id_ex_bubble === 1'b1 && n < 20) begin n++; tick(); end
    vec_cnt++;
    if (n !== 1 || busy_vec[5] !== 1'b0) begin
      err_cnt++;
      $display("FAIL load_use_bubbles: got %0d busy5=%b, want 1 bubble busy5=0", n, busy_vec[5]);
    end
    tick();
    idle();
  endtask

  task automatic test_multi_cycle();
    int n;
    do_reset();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 4'd3, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd2, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 4'd0, 1'b0, 5'd0);
    vec_cnt++;
    if (id_ex_bubble !== 1'b0) begin
      err_cnt++;
      $display("FAIL mul_independent: bubble=%b want 0", id_ex_bubble);
    end
    tick();
    drive(1'b1, 1'b0, 5'd1, 1'b1, 5'd7, 1'b1, 5'd10, 1'b1, 4'd0, 1'b0, 5'd0);
    n = 0;
    while (id_ex_bubble === 1'b1 && n < 20) begin n++; tick(); end
    vec_cnt++;
    if (n !== 2) begin
      // one cycle already elapsed issuing the independent op, so 3-1 remain
      err_cnt++;
      $display("FAIL mul_dep_after_gap: got %0d stall cycles, want 2", n);
    end
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 4'd3, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 4'd0, 1'b0, 5'd0);
    n = 0;
    while (id_ex_bubble === 1'b1 && n < 20) begin n++; tick(); end
    vec_cnt++;
    if (n !== 3) begin
      err_cnt++;
      $display("FAIL mul_dep: got %0d stall cycles, want 3", n);
    end
    tick();
    idle();
  endtask

  task automatic test_variable_latency();
    int n;
    do_reset();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, LAT_UNKNOWN, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 4'd0, 1'b0, 5'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (id_ex_bubble === 1'b1) n++;
      tick();
    end
    vec_cnt++;
    if (n !== 10 || busy_vec[9] !== 1'b1) begin
      err_cnt++;
      $display("FAIL div_hold: stalled %0d of 10 busy9=%b, want 10 busy9=1", n, busy_vec[9]);
    end
    drive(1'b1, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 4'd0, 1'b1, 5'd9);
    vec_cnt++;
    if (id_ex_bubble !== 1'b1) begin
      err_cnt++;
      $display("FAIL div_no_bypass: bubble=%b want 1", id_ex_bubble);
    end
    tick();
    drive(1'b1, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 4'd0, 1'b0, 5'd0);
    vec_cnt++;
    if (id_ex_bubble !== 1'b0 || busy_vec[9] !== 1'b0) begin
      err_cnt++;
      $display("FAIL div_release: bubble=%b busy9=%b want 0/0", id_ex_bubble, busy_vec[9]);
    end
    tick();
    idle();
  endtask

  task automatic test_waw_x0();
    int n;
    do_reset();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, LAT_UNKNOWN, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, LAT_LOAD, 1'b0, 5'd0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (id_ex_bubble === 1'b1) n++;
      tick();
    end
    vec_cnt++;
    if (n !== 5) begin
      err_cnt++;
      $display("FAIL waw_hold: stalled %0d of 5, want 5", n);
    end
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, LAT_LOAD, 1'b1, 5'd9);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, LAT_LOAD, 1'b0, 5'd0);
    vec_cnt++;
    if (id_ex_bubble !== 1'b0) begin
      err_cnt++;
      $display("FAIL waw_release: bubble=%b want 0", id_ex_bubble);
    end
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'd3, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 4'd0, 1'b0, 5'd0);
    vec_cnt++;
    if (id_ex_bubble !== 1'b0 || busy_vec[0] !== 1'b0) begin
      err_cnt++;
      $display("FAIL x0_never_busy: bubble=%b busy0=%b want 0/0", id_ex_bubble, busy_vec[0]);
    end
    tick();
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 4'd2, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 4'd3, 1'b0, 5'd0);
    vec_cnt++;
    if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_override: pc=%b bub=%b want 1/0", pc_write, id_ex_bubble);
    end
    tick();
    idle();
    vec_cnt++;
    if (busy_vec[6] !== 1'b0 || busy_vec[5] !== 1'b1) begin
      err_cnt++;
      $display("FAIL flush_no_issue: busy6=%b busy5=%b want 0/1", busy_vec[6], busy_vec[5]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 4'd2, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 4'd0, 1'b0, 5'd0);
    vec_cnt++;
    if (pc_write !== 1'b0 || busy_vec[5] !== 1'b1) begin
      err_cnt++;
      $display("FAIL pre_reset_stall: pc=%b busy5=%b want 0/1", pc_write, busy_vec[5]);
    end
    #2;
    rst_n = 1'b0;
    m_clear();
    #1;
    vec_cnt++;
    if (busy_vec !== 32'd0 || pc_write !== 1'b1 || if_id_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
      err_cnt++;
      $display("FAIL async_reset: busy=%h pc=%b ifid=%b bub=%b want 0/1/1/0",
               busy_vec, pc_write, if_id_write, id_ex_bubble);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_random();
    int nerr;
    logic [3:0] lat;
    logic [4:0] wr;
    logic wbd;
    bit st;
    do_reset();
    nerr = 0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: lat = 4'd0;
        1: lat = 4'd1;
        2: lat = 4'd2;
        3: lat = 4'hF;
        default: lat = 4'($urandom_range(0, 15));
      endcase
      wbd = 1'b0;
      wr = 5'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        wbd = 1'b1;
        for (int r = 1; r < 16; r++) if (wt_m[r] && $urandom_range(0, 1) == 1) wr = 5'(r);
      end
      drive(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) == 0),
            5'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), lat, wbd, wr);
      st = m_stall();
      vec_cnt++;
      if (id_ex_bubble !== st || pc_write !== !st || if_id_write !== !st || busy_vec !== m_busy_vec()) begin
        err_cnt++;
        nerr++;
        if (nerr < 10)
          $display("FAIL random[%0d]: bub=%b pc=%b busy=%h, want bub=%b busy=%h",
                   i, id_ex_bubble, pc_write, busy_vec, st, m_busy_vec());
      end
      tick();
    end
    idle();
  endtask

`ifdef HAZARD_SB_PERF_EN
  task automatic test_perf();
    int n;
    do_reset();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, LAT_LOAD, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 4'd0, 1'b0, 5'd0);
    n = 0;
    while (id_ex_bubble === 1'b1 && n < 20) begin n++; tick(); end
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 4'd3, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 4'd0, 1'b0, 5'd0);
    n = 0;
    while (id_ex_bubble === 1'b1 && n < 20) begin n++; tick(); end
    tick();
    idle();
    vec_cnt++;
    if (perf_stall_cycles !== 32'd4 || perf_raw_events !== 32'd2 || perf_waw_events !== 32'd0) begin
      err_cnt++;
      $display("FAIL perf_counts: %0d/%0d/%0d, want 4/2/0",
               perf_stall_cycles, perf_raw_events, perf_waw_events);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_multi_cycle();
    test_variable_latency();
    test_waw_x0();
    test_flush();
    test_async_reset();
    test_random();
`ifdef HAZARD_SB_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational load-use hazard detector for the RISC-V pipeline.
- Holds a per-register scoreboard of pending writes from fixed-latency units (load, multiplier) and variable-latency units (divider, uncached memory). Each pending entry has a countdown counter or a wait-for-completion flag.
- Sits beside the ID stage. Drives PC/IF-ID write enables and an ID/EX bubble; detects RAW and WAW hazards.

Parameters:
- REG_ADDR_W, 5, register index width.
- NUM_REGS, 32, architectural registers tracked; index 0 is hard-wired zero.
- LAT_W, 4, latency counter width. The all-ones code (LAT_UNKNOWN) means variable latency.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_flush  in  1  ID instruction squashed (branch redirect) this cycle.
- id_rs1, id_rs2  in  REG_ADDR_W  source register indices.
- id_rs1_used, id_rs2_used  in  1  source actually read.
- id_rd  in  REG_ADDR_W  destination index.
- id_rd_we  in  1  instruction writes rd.
- id_lat  in  LAT_W  cycles until rd is forwardable. 0 = forwardable from EX; LAT_UNKNOWN = wait for wb_done.
- wb_done  in  1  variable-latency unit completed.
- wb_rd  in  REG_ADDR_W  register completed by wb_done.
- pc_write  out  1  PC may update.
- if_id_write  out  1  IF/ID register may update.
- id_ex_bubble  out  1  insert NOP into ID/EX.
- busy_vec  out  NUM_REGS  per-register pending flag (debug/forwarding mux).

Behaviour:
- Reset (async, rst_n=0): all counters 0, all wait flags 0. busy_vec=0, pc_write=1, if_id_write=1, id_ex_bubble=0.
- busy[r] = (count[r]!=0) | wait[r], taken from registered state only. busy[0] is always 0.
- raw = (id_rs1_used & busy[id_rs1]) | (id_rs2_used & busy[id_rs2]).
- waw = id_rd_we & busy[id_rd].
- stall = id_valid & ~id_flush & (raw | waw). This is combinational, with zero-cycle latency.
- Output mapping: pc_write = ~stall, if_id_write = ~stall, id_ex_bubble = stall.
- An instruction issues when id_valid & ~id_flush & ~stall. On the issue edge, if id_rd_we & id_rd!=0:
  - id_lat = 0: no entry.
  - id_lat in 1..LAT_UNKNOWN-1: count[id_rd] <= id_lat.
  - id_lat = LAT_UNKNOWN: wait[id_rd] <= 1.
- Countdown: every edge, each nonzero count decrements by 1. A dependent instruction therefore stalls exactly id_lat cycles (classic load-use: id_lat=1 gives 1 bubble).
- Completion: wb_done clears wait[wb_rd] on the next edge. wb_done for a non-waiting register or for x0 is ignored.
- Simultaneous events:
  - Issue to the same rd as wb_done cannot occur, because WAW holds the issue.
  - The same-cycle clear of wait[wb_rd] is not visible to stall until the next cycle; there is no bypass.
  - A count reaching 0 on an edge frees the register for the following cycle.
- id_flush overrides stall, so a squashed instruction never blocks fetch redirect and never issues.
- Reset mid-operation clears all pending state immediately. In-flight results are dropped by the pipeline reset.

Optional Feature:
- Macro HAZARD_SB_PERF_EN.
- Defined: adds outputs perf_stall_cycles (32), perf_raw_events (32) and perf_waw_events (32), each reset to 0 and saturating at all-ones.
  - perf_stall_cycles increments each cycle stall=1.
  - perf_raw_events and perf_waw_events increment on the first cycle of each stall episode, classified RAW if raw=1, else WAW.
- Undefined: these ports and all counter logic are absent. Core behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - REG_ADDR_W and LAT_W defaults.
  - The LAT_UNKNOWN constant (all-ones of LAT_W).
  - The LAT_LOAD=1 and LAT_MUL=2 constants used by the decoder.
- Sub-module hazard_sb_entry:
  - One register's counter plus wait flag, with set/decrement/clear and a busy output.
  - Instantiated for indices 1..NUM_REGS-1 by a generate loop; index 0 is tied not-busy.

Test Plan:
- Load-use: issue lw x5 (id_lat=1), next cycle add x6,x5,x1 with rs1_used=1 -> exactly 1 cycle of pc_write=0, id_ex_bubble=1, then issue; busy_vec[5] high for 1 cycle.
- Multi-cycle: issue mul x7 (id_lat=3), dependent uses x7 -> 3 stall cycles. Independent instruction (rs1=x2, rs2=x3) -> no stall.
- Variable latency: issue div x9 (id_lat=4'hF), dependent waits 10 cycles -> stall held. wb_done with wb_rd=9 -> stall drops the cycle after, and busy_vec[9]=0.
- WAW plus x0: pending div x9, then lw x9 with no sources -> stall until wb_done. Writing x0 with id_lat=3, then reading x0 -> never stalls.
- Flush and reset: a stalled dependent in ID with id_flush=1 -> pc_write=1, no issue. Assert rst_n=0 while x5 count=2 -> busy_vec=0 asynchronously, outputs at reset values.
- (HAZARD_SB_PERF_EN) the load-use plus mul sequence -> perf_stall_cycles=4, perf_raw_events=2, perf_waw_events=0.
